alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 122 ++++++++++++
 tb/tb_alu_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester front end for a shared single-cycle ALU: arbitrates, holds one
// operation in flight, and returns the registered result to the granted requester.
module alu_arbiter #(
  parameter bit RR_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req_valid,
  output logic [1:0] req_ready,
  input  logic [3:0] req_cmd0,
  input  logic [3:0] req_cmd1,
  input  logic [7:0] req_a0,
  input  logic [7:0] req_b0,
  input  logic [7:0] req_a1,
  input  logic [7:0] req_b1,
  output logic [3:0] alu_cmd,
  output logic [7:0] alu_inA,
  output logic [7:0] alu_inB,
  output logic       alu_sc_i,
  input  logic [7:0] alu_rslt,
  input  logic       alu_sc_o,
  input  logic       alu_one,
  output logic [1:0] rsp_valid,
  input  logic [1:0] rsp_ready,
  output logic [7:0] rsp_rslt,
  output logic       rsp_one,
  output logic       rsp_pari
);

  typedef enum logic [1:0] {IDLE = 2'd0, EXEC = 2'd1, RESP = 2'd2} state_t;

  typedef struct packed {
    logic [3:0] cmd;
    logic [7:0] a;
    logic [7:0] b;
  } op_t;

  localparam logic [3:0] CMD_EQ = 4'b1101;
  localparam logic [3:0] CMD_LT = 4'b1110;

  state_t        state, state_nxt;
  op_t     [1:0] req_op;
  op_t           hold_op;
  logic          hold_id;
  logic          last_grant;
  logic    [1:0] carry;
  logic          gnt_id;
  logic          accept;

  assign req_op[0] = '{cmd: req_cmd0, a: req_a0, b: req_b0};
  assign req_op[1] = '{cmd: req_cmd1, a: req_a1, b: req_b1};

  assign alu_cmd  = hold_op.cmd;
  assign alu_inA  = hold_op.a;
  assign alu_inB  = hold_op.b;
  assign alu_sc_i = carry[hold_id];
  assign accept   = |(req_valid & req_ready);

  // Tie-break: alternate away from the last winner, or always favour requester 0.
  always_comb begin
    gnt_id = 1'b0;
    if (&req_valid)
      gnt_id = RR_EN ? ~last_grant : 1'b0;
    else if (req_valid[1])
      gnt_id = 1'b1;
  end

  // Handshake outputs are masked while reset is asserted so nothing is accepted
  // or reported from a state that is about to be discarded.
  always_comb begin
    state_nxt = state;
    req_ready = 2'b00;
    rsp_valid = 2'b00;
    case (state)
      IDLE: begin
        if (rst_n && |req_valid) begin
          req_ready[gnt_id] = 1'b1;
          state_nxt         = EXEC;
        end
      end
      EXEC: state_nxt = RESP;
      RESP: begin
        rsp_valid[hold_id] = rst_n;
        if (rsp_ready[hold_id])
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_op    <= '0;
      hold_id    <= 1'b0;
      last_grant <= 1'b1;
      carry      <= 2'b00;
      rsp_rslt   <= 8'h00;
      rsp_one    <= 1'b0;
      rsp_pari   <= 1'b0;
    end else begin
      if (accept) begin
        hold_op    <= req_op[gnt_id];
        hold_id    <= gnt_id;
        last_grant <= gnt_id;
      end
      if (state == EXEC) begin
        rsp_rslt       <= alu_rslt;
        rsp_pari       <= ^alu_rslt;
        rsp_one        <= (hold_op.cmd == CMD_EQ || hold_op.cmd == CMD_LT) ? alu_one : 1'b0;
        carry[hold_id] <= alu_sc_o;
      end
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: a behavioural ALU per DUT, round-robin and
// fixed-priority instances driven from the same requesters.
module tb_alu_arbiter;

  localparam logic [3:0] ADD = 4'b0000;
  localparam logic [3:0] ADC = 4'b0001;
  localparam logic [3:0] EQ  = 4'b1101;
  localparam logic [3:0] LT  = 4'b1110;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] req_valid;
  logic [3:0] req_cmd0, req_cmd1;
  logic [7:0] req_a0, req_b0, req_a1, req_b1;
  logic [1:0] rsp_ready;

  logic [1:0] req_ready, rsp_valid;
  logic [3:0] alu_cmd;
  logic [7:0] alu_inA, alu_inB, alu_rslt, rsp_rslt;
  logic       alu_sc_i, alu_sc_o, alu_one, rsp_one, rsp_pari;

  logic [1:0] fp_req_ready, fp_rsp_valid;
  logic [3:0] fp_alu_cmd;
  logic [7:0] fp_alu_inA, fp_alu_inB, fp_alu_rslt, fp_rsp_rslt;
  logic       fp_alu_sc_i, fp_alu_sc_o, fp_alu_one, fp_rsp_one, fp_rsp_pari;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // Returns {carry_out, compare_flag, result}; non-compare ops drive the flag
  // high so the arbiter's masking of it is visible.
  function automatic logic [9:0] alu_f(input logic [3:0] c, input logic [7:0] a,
                                       input logic [7:0] b, input logic ci);
    logic [8:0] s;
    logic [9:0] r;
    s = 9'd0;
    case (c)
      ADD:     begin s = {1'b0, a} + {1'b0, b};                 r = {s[8], 1'b1, s[7:0]}; end
      ADC:     begin s = {1'b0, a} + {1'b0, b} + {8'd0, ci};    r = {s[8], 1'b1, s[7:0]}; end
      EQ:      r = {1'b0, (a == b), 7'd0, (a == b)};
      LT:      r = {1'b0, (a < b), 7'd0, (a < b)};
      default: r = {1'b0, 1'b1, a ^ b};
    endcase
    return r;
  endfunction

  assign {alu_sc_o, alu_one, alu_rslt}          = alu_f(alu_cmd, alu_inA, alu_inB, alu_sc_i);
  assign {fp_alu_sc_o, fp_alu_one, fp_alu_rslt} = alu_f(fp_alu_cmd, fp_alu_inA, fp_alu_inB, fp_alu_sc_i);

  alu_arbiter #(.RR_EN(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd0(req_cmd0), .req_cmd1(req_cmd1), .req_a0(req_a0), .req_b0(req_b0),
    .req_a1(req_a1), .req_b1(req_b1), .alu_cmd(alu_cmd), .alu_inA(alu_inA),
    .alu_inB(alu_inB), .alu_sc_i(alu_sc_i), .alu_rslt(alu_rslt), .alu_sc_o(alu_sc_o),
    .alu_one(alu_one), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rslt(rsp_rslt), .rsp_one(rsp_one), .rsp_pari(rsp_pari)
  );

  alu_arbiter #(.RR_EN(1'b0)) u_fp (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(fp_req_ready),
    .req_cmd0(req_cmd0), .req_cmd1(req_cmd1), .req_a0(req_a0), .req_b0(req_b0),
    .req_a1(req_a1), .req_b1(req_b1), .alu_cmd(fp_alu_cmd), .alu_inA(fp_alu_inA),
    .alu_inB(fp_alu_inB), .alu_sc_i(fp_alu_sc_i), .alu_rslt(fp_alu_rslt),
    .alu_sc_o(fp_alu_sc_o), .alu_one(fp_alu_one), .rsp_valid(fp_rsp_valid),
    .rsp_ready(rsp_ready), .rsp_rslt(fp_rsp_rslt), .rsp_one(fp_rsp_one),
    .rsp_pari(fp_rsp_pari)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic set_op(input int id, input logic [3:0] cmd, input logic [7:0] a, input logic [7:0] b);
    if (id == 0) begin req_cmd0 = cmd; req_a0 = a; req_b0 = b; end
    else         begin req_cmd1 = cmd; req_a1 = a; req_b1 = b; end
  endtask

  // Called at a negedge; returns at the negedge just after the accept edge (EXEC).
  task automatic issue(input int id, input logic [3:0] cmd, input logic [7:0] a, input logic [7:0] b);
    int n;
    logic [1:0] oh;
    oh = 2'b01 << id;
    set_op(id, cmd, a, b);
    req_valid = oh;
    #1;
    n = 0;
    while (req_ready != oh && n < 10) begin
      @(negedge clk); #1; n++;
    end
    chk("accept_grant", {30'd0, req_ready}, {30'd0, oh});
    @(negedge clk);
    req_valid = 2'b00;
  endtask

  task automatic wait_rsp(input int id);
    int n;
    logic [1:0] oh;
    oh = 2'b01 << id;
    n = 0;
    #1;
    while (rsp_valid != oh && n < 10) begin
      @(negedge clk); #1; n++;
    end
    chk("rsp_valid", {30'd0, rsp_valid}, {30'd0, oh});
  endtask

  task automatic run_op(input string tag, input int id, input logic [3:0] cmd,
                        input logic [7:0] a, input logic [7:0] b,
                        input logic [7:0] er, input logic eone, input logic epar);
    issue(id, cmd, a, b);
    wait_rsp(id);
    chk({tag, "_rslt"}, {24'd0, rsp_rslt}, {24'd0, er});
    chk({tag, "_one"},  {31'd0, rsp_one},  {31'd0, eone});
    chk({tag, "_pari"}, {31'd0, rsp_pari}, {31'd0, epar});
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst_n     = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 2'b11;
    set_op(0, ADD, 8'h00, 8'h00);
    set_op(1, ADD, 8'h00, 8'h00);

    // reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req_ready", {30'd0, req_ready}, 32'd0);
    chk("rst_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    chk("rst_rslt",      {24'd0, rsp_rslt},  32'd0);
    chk("rst_alu_inA",   {24'd0, alu_inA},   32'd0);
    chk("rst_sc_i",      {31'd0, alu_sc_i},  32'd0);
    req_valid = 2'b00;
    rst_n     = 1'b1;
    @(negedge clk);

    // single add with latency and fixed-priority twin agreeing
    issue(0, ADD, 8'h05, 8'h03);
    req_valid = 2'b11;
    #1;
    chk("exec_req_ready", {30'd0, req_ready}, 32'd0);
    chk("exec_rsp_valid", {30'd0, rsp_valid}, 32'd0);
    req_valid = 2'b00;
    @(negedge clk); #1;
    chk("add_rsp_valid", {30'd0, rsp_valid}, 32'd1);
    chk("add_rslt",      {24'd0, rsp_rslt},  32'h08);
    chk("add_pari",      {31'd0, rsp_pari},  32'd1);
    chk("add_one",       {31'd0, rsp_one},   32'd0);
    chk("fp_add_rslt",   {24'd0, fp_rsp_rslt}, 32'h08);
    chk("fp_add_flags",  {29'd0, fp_rsp_valid, fp_rsp_one}, 32'b010);
    chk("fp_add_pari",   {31'd0, fp_rsp_pari}, 32'd1);
    @(negedge clk); #1;
    chk("add_done_valid", {30'd0, rsp_valid}, 32'd0);

    // operand isolation: req_a0 changes right after accept
    issue(0, ADD, 8'h01, 8'h01);
    req_a0 = 8'hFF;
    wait_rsp(0);
    chk("iso_rslt", {24'd0, rsp_rslt}, 32'h02);
    @(negedge clk);

    // per-requester carry registers
    run_op("adc0a", 0, ADC, 8'hFF, 8'h01, 8'h00, 1'b0, 1'b0);
    run_op("adc0b", 0, ADC, 8'h01, 8'h01, 8'h03, 1'b0, 1'b0);
    run_op("adc1",  1, ADC, 8'h01, 8'h01, 8'h02, 1'b0, 1'b1);

    // compares from requester 1
    run_op("eq", 1, EQ, 8'h2A, 8'h2A, 8'h01, 1'b1, 1'b1);
    run_op("lt", 1, LT, 8'h30, 8'h10, 8'h00, 1'b0, 1'b0);

    // backpressure in RESP
    rsp_ready = 2'b00;
    issue(0, ADD, 8'h10, 8'h20);
    wait_rsp(0);
    req_valid = 2'b11;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); #1;
      chk("bp_valid", {30'd0, rsp_valid}, 32'd1);
      chk("bp_rslt",  {24'd0, rsp_rslt},  32'h30);
      chk("bp_ready", {30'd0, req_ready}, 32'd0);
    end
    rsp_ready = 2'b10;
    @(negedge clk); #1;
    chk("bp_wrong_bit_valid", {30'd0, rsp_valid}, 32'd1);
    rsp_ready = 2'b01;
    @(negedge clk); #1;
    chk("bp_release_valid", {30'd0, rsp_valid},    32'd0);
    chk("bp_idle_rr",       {30'd0, req_ready},    32'b10);
    chk("bp_idle_fp",       {30'd0, fp_req_ready}, 32'b01);
    req_valid = 2'b00;
    rsp_ready = 2'b11;
    @(negedge clk);

    // reset while in EXEC
    issue(1, ADD, 8'h07, 8'h07);
    rst_n = 1'b0;
    @(negedge clk); #1;
    chk("rstx_valid", {30'd0, rsp_valid}, 32'd0);
    chk("rstx_rslt",  {24'd0, rsp_rslt},  32'd0);
    chk("rstx_pari",  {31'd0, rsp_pari},  32'd0);
    chk("rstx_inA",   {24'd0, alu_inA},   32'd0);
    rst_n = 1'b1;
    @(negedge clk); #1;
    chk("rstx_after_valid", {30'd0, rsp_valid}, 32'd0);
    req_valid = 2'b11;
    #1;
    chk("rstx_tie", {30'd0, req_ready}, 32'b01);

    // continuous tie: round-robin alternates, fixed priority keeps requester 0
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (req_ready == 2'b00 && n < 10) begin
        @(negedge clk); #1; n++;
      end
      chk("rr_grant", {30'd0, req_ready}, (k % 2 == 0) ? 32'b01 : 32'b10);
      if (k < 3) chk("fp_grant", {30'd0, fp_req_ready}, 32'b01);
      @(negedge clk); #1;
    end
    req_valid = 2'b00;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
